spi_xfer_arbiter: RTL and testbench

SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

---
 rtl/spi_xfer_arbiter_if.sv | 37 +++
 rtl/spi_xfer_arbiter.sv | 148 ++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_arbiter_if.sv
// Bundle between the two-requester SPI transfer arbiter, its requesters and the SPI byte core.
// req_i is a level request held until done_o/err_o; tx_rd_o, rx_valid_o, done_o and err_o are
// single-cycle strobes with no backpressure; core_valid_i is only accepted while waiting for a byte.
interface spi_xfer_arbiter_if #(
  parameter int BYTE_SIZE = 8
);
  logic [1:0]           req_i;
  logic [3:0]           len0_i;
  logic [3:0]           len1_i;
  logic [BYTE_SIZE-1:0] txd0_i;
  logic [BYTE_SIZE-1:0] txd1_i;
  logic [1:0]           tx_rd_o;
  logic [BYTE_SIZE-1:0] rx_data_o;
  logic [1:0]           rx_valid_o;
  logic [1:0]           gnt_o;
  logic [1:0]           done_o;
  logic [1:0]           err_o;
  logic [1:0]           ssn_o;
  logic [BYTE_SIZE-1:0] core_data_o;
  logic                 core_wren_o;
  logic [8:0]           core_clk_div_o;
  logic [BYTE_SIZE-1:0] core_data_i;
  logic                 core_valid_i;
  logic [2:0]           state_o;

  modport slave (
    input  req_i, len0_i, len1_i, txd0_i, txd1_i, core_data_i, core_valid_i,
    output tx_rd_o, rx_data_o, rx_valid_o, gnt_o, done_o, err_o, ssn_o,
           core_data_o, core_wren_o, core_clk_div_o, state_o
  );

  modport master (
    output req_i, len0_i, len1_i, txd0_i, txd1_i, core_data_i, core_valid_i,
    input  tx_rd_o, rx_data_o, rx_valid_o, gnt_o, done_o, err_o, ssn_o,
           core_data_o, core_wren_o, core_clk_div_o, state_o
  );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter giving two requesters exclusive use of one SPI byte core, framing each
// multi-byte transfer with chip-select setup/hold and a per-byte response timeout.
module spi_xfer_arbiter #(
  parameter int         BYTE_SIZE = 8,
  parameter int         SETUP_CYC = 4,
  parameter int         HOLD_CYC  = 4,
  parameter logic [8:0] DIV0      = 9'd1,
  parameter logic [8:0] DIV1      = 9'd1,
  parameter int         TMO_CYC   = 1023
) (
  input  logic clk_i,
  input  logic rst_i,
  spi_xfer_arbiter_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam int CW = $clog2(TMO_CYC + 1);

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_cnt;
  logic [4:0]           r_rem;
  logic                 r_sel;
  logic                 r_last;
  logic [1:0]           r_gnt;
  logic [1:0]           r_ssn;
  logic [1:0]           r_rx_valid;
  logic [1:0]           r_done;
  logic [1:0]           r_err;
  logic [BYTE_SIZE-1:0] r_rx_data;
  logic [8:0]           r_div;

  logic       w_req_any;
  logic       w_win;
  logic [3:0] w_len;
  logic [1:0] w_sel_oh;
  logic       w_setup_end;
  logic       w_hold_end;
  logic       w_tmo;

  // On a tie the requester that did not win last time gets the bus.
  assign w_req_any   = |bus.req_i;
  assign w_win       = (bus.req_i == 2'b11) ? ~r_last : bus.req_i[1];
  assign w_len       = w_win ? bus.len1_i : bus.len0_i;
  assign w_sel_oh    = r_sel ? 2'b10 : 2'b01;
  assign w_setup_end = (r_cnt == CW'(SETUP_CYC - 1));
  assign w_hold_end  = (r_cnt == CW'(HOLD_CYC - 1));
  // The LOAD cycle counts as the first of the TMO_CYC budget, so WAIT gives up one cycle earlier.
  assign w_tmo       = (r_cnt == CW'(TMO_CYC - 2));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req_any) w_next = S_SETUP;
      S_SETUP: if (w_setup_end) w_next = S_LOAD;
      S_LOAD:  w_next = S_WAIT;
      S_WAIT: begin
        if (bus.core_valid_i)  w_next = (r_rem <= 5'd1) ? S_HOLD : S_LOAD;
        else if (w_tmo)        w_next = S_IDLE;
      end
      S_HOLD:  if (w_hold_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.core_wren_o = 1'b0;
    bus.core_data_o = '0;
    bus.tx_rd_o     = 2'b00;
    if (r_state == S_LOAD) begin
      bus.core_wren_o = 1'b1;
      bus.core_data_o = r_sel ? bus.txd1_i : bus.txd0_i;
      bus.tx_rd_o     = w_sel_oh;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_rem      <= 5'd0;
      r_sel      <= 1'b0;
      r_last     <= 1'b1;
      r_gnt      <= 2'b00;
      r_ssn      <= 2'b11;
      r_rx_valid <= 2'b00;
      r_done     <= 2'b00;
      r_err      <= 2'b00;
      r_rx_data  <= '0;
      r_div      <= DIV0;
    end else begin
      r_rx_valid <= 2'b00;
      r_done     <= 2'b00;
      r_err      <= 2'b00;
      r_cnt      <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_sel  <= w_win;
            r_last <= w_win;
            r_gnt  <= w_win ? 2'b10 : 2'b01;
            r_ssn  <= w_win ? 2'b01 : 2'b10;
            r_rem  <= (w_len == 4'd0) ? 5'd16 : {1'b0, w_len};
            r_div  <= w_win ? DIV1 : DIV0;
          end
        end
        S_WAIT: begin
          if (bus.core_valid_i) begin
            r_rx_data  <= bus.core_data_i;
            r_rx_valid <= w_sel_oh;
            if (r_rem != 5'd0) r_rem <= r_rem - 5'd1;
          end else if (w_tmo) begin
            r_ssn <= 2'b11;
            r_gnt <= 2'b00;
            r_err <= w_sel_oh;
          end
        end
        S_HOLD: begin
          if (w_hold_end) begin
            r_ssn  <= 2'b11;
            r_gnt  <= 2'b00;
            r_done <= w_sel_oh;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt_o          = r_gnt;
  assign bus.ssn_o          = r_ssn;
  assign bus.rx_valid_o     = r_rx_valid;
  assign bus.rx_data_o      = r_rx_data;
  assign bus.done_o         = r_done;
  assign bus.err_o          = r_err;
  assign bus.core_clk_div_o = r_div;
  assign bus.state_o        = r_state;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter: reset values, framing, round-robin, 16-byte length,
// timeout, reset abort and spurious core responses, with a byte-level scoreboard.
module tb_spi_xfer_arbiter;
  localparam logic [8:0] TB_DIV0  = 9'd1;
  localparam logic [8:0] TB_DIV1  = 9'd5;
  localparam int         TMO      = 1023;
  localparam int         CORE_LAT = 3;

  logic clk;
  logic rst;

  spi_xfer_arbiter_if #(.BYTE_SIZE(8)) bus ();

  spi_xfer_arbiter #(
    .BYTE_SIZE(8), .SETUP_CYC(4), .HOLD_CYC(4),
    .DIV0(TB_DIV0), .DIV1(TB_DIV1), .TMO_CYC(TMO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx0_tbl[64];
  logic [7:0] tx1_tbl[64];
  logic [7:0] rsp_tbl[64];
  int tx_ptr0 = 0, tx_ptr1 = 0, rsp_ptr = 0;
  int c_wren = 0, c_rxv0 = 0, c_rxv1 = 0, c_done0 = 0, c_done1 = 0;
  int c_err0 = 0, c_err1 = 0, c_viol = 0, c_divbad = 0;
  int gnt_n = 0;
  logic gnt_log[64];
  logic core_en;
  logic spur_mode;

  assign bus.txd0_i = tx0_tbl[tx_ptr0 & 63];
  assign bus.txd1_i = tx1_tbl[tx_ptr1 & 63];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // core model: answers each write after CORE_LAT cycles; optionally injects junk outside WAIT
  initial begin : core_model
    int rsp_cnt;
    rsp_cnt = 0;
    bus.core_valid_i = 1'b0;
    bus.core_data_i  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        rsp_cnt = 0;
        bus.core_valid_i = 1'b0;
      end else begin
        if (rsp_cnt != 0) begin
          rsp_cnt--;
          bus.core_valid_i = (rsp_cnt == 0);
          if (rsp_cnt == 0) begin
            bus.core_data_i = rsp_tbl[rsp_ptr & 63];
            rsp_ptr++;
          end
        end else begin
          bus.core_valid_i = spur_mode && (bus.state_o != 3'd3);
          bus.core_data_i  = spur_mode ? 8'hEE : 8'h00;
        end
        if (bus.core_wren_o && core_en) rsp_cnt = CORE_LAT;
      end
    end
  end

  // monitor: event counters, tx/rx byte checks, invariants
  initial begin : monitor
    logic pend0, pend1;
    logic [1:0] prev_gnt;
    pend0 = 1'b0; pend1 = 1'b0; prev_gnt = 2'b00;
    forever begin
      @(negedge clk);
      if (pend0) tx_ptr0++;
      if (pend1) tx_ptr1++;
      pend0 = bus.tx_rd_o[0];
      pend1 = bus.tx_rd_o[1];
      if (bus.core_wren_o) begin
        c_wren++;
        check_eq("tx_byte", {24'h0, bus.core_data_o},
                 {24'h0, bus.gnt_o[1] ? tx1_tbl[tx_ptr1 & 63] : tx0_tbl[tx_ptr0 & 63]});
      end
      if (bus.rx_valid_o != 2'b00) begin
        if (bus.rx_valid_o[0]) c_rxv0++;
        if (bus.rx_valid_o[1]) c_rxv1++;
        if (exp_q.size() == 0) check_eq("rx_unexpected", {30'h0, bus.rx_valid_o}, 32'h0);
        else                   check_eq("rx_data", {24'h0, bus.rx_data_o}, {24'h0, exp_q.pop_front()});
      end
      if (bus.done_o[0]) c_done0++;
      if (bus.done_o[1]) c_done1++;
      if (bus.err_o[0])  c_err0++;
      if (bus.err_o[1])  c_err1++;
      if (bus.ssn_o == 2'b00 || (bus.core_wren_o && bus.state_o != 3'd2)) c_viol++;
      if ((bus.gnt_o[1] && bus.core_clk_div_o != TB_DIV1) ||
          (bus.gnt_o[0] && bus.core_clk_div_o != TB_DIV0)) c_divbad++;
      if (bus.gnt_o != 2'b00 && prev_gnt == 2'b00) begin
        gnt_log[gnt_n & 63] = bus.gnt_o[1];
        gnt_n++;
      end
      prev_gnt = bus.gnt_o;
    end
  end

  // driver tasks
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_end(input int budget, output logic [1:0] d, output logic [1:0] e);
    d = 2'b00;
    e = 2'b00;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (bus.done_o != 2'b00 || bus.err_o != 2'b00) begin
        d = bus.done_o;
        e = bus.err_o;
        bus.req_i = bus.req_i & ~(bus.done_o | bus.err_o);
        return;
      end
    end
  endtask

  task automatic wait_wren(input int budget);
    for (int n = 0; n < budget && !bus.core_wren_o; n++) @(negedge clk);
  endtask

  initial begin : main
    logic [1:0] d, e;
    int n, b_wren, b_rxv0, b_rxv1, b_done0, b_done1, b_err0, b_err1, b_div, g0, p0;
    for (int i = 0; i < 64; i++) begin
      tx0_tbl[i] = 8'h00; tx1_tbl[i] = 8'h00; rsp_tbl[i] = 8'h00;
    end
    rst = 1'b1; core_en = 1'b1; spur_mode = 1'b0;
    bus.req_i = 2'b00; bus.len0_i = 4'd0; bus.len1_i = 4'd0;
    settle(3);
    check_eq("rst_ssn",      {30'h0, bus.ssn_o}, 32'h3);
    check_eq("rst_gnt",      {30'h0, bus.gnt_o}, 32'h0);
    check_eq("rst_wren",     {31'h0, bus.core_wren_o}, 32'h0);
    check_eq("rst_cdata",    {24'h0, bus.core_data_o}, 32'h0);
    check_eq("rst_rxdata",   {24'h0, bus.rx_data_o}, 32'h0);
    check_eq("rst_pulses",   {24'h0, bus.rx_valid_o, bus.done_o, bus.err_o, bus.tx_rd_o}, 32'h0);
    check_eq("rst_div",      {23'h0, bus.core_clk_div_o}, {23'h0, TB_DIV0});
    check_eq("rst_state",    {29'h0, bus.state_o}, 32'h0);
    rst = 1'b0;

    // round-robin: tie after reset goes to 0, then 1, then tie again goes to 0
    settle(1);
    g0 = gnt_n;
    tx0_tbl[tx_ptr0 & 63] = 8'h10; tx0_tbl[(tx_ptr0 + 1) & 63] = 8'h12;
    tx1_tbl[tx_ptr1 & 63] = 8'h21; tx1_tbl[(tx_ptr1 + 1) & 63] = 8'h23;
    rsp_tbl[rsp_ptr & 63] = 8'h11; rsp_tbl[(rsp_ptr + 1) & 63] = 8'h22;
    rsp_tbl[(rsp_ptr + 2) & 63] = 8'h33; rsp_tbl[(rsp_ptr + 3) & 63] = 8'h44;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    bus.len0_i = 4'd1; bus.len1_i = 4'd1; bus.req_i = 2'b11;
    wait_end(200, d, e); check_eq("rr_done_a", {30'h0, d}, 32'h1);
    wait_end(200, d, e); check_eq("rr_done_b", {30'h0, d}, 32'h2);
    bus.req_i = 2'b11;
    wait_end(200, d, e); check_eq("rr_done_c", {30'h0, d}, 32'h1);
    wait_end(200, d, e); check_eq("rr_done_d", {30'h0, d}, 32'h2);
    settle(2);
    check_eq("rr_grants", gnt_n - g0, 32'd4);
    check_eq("rr_order", {28'h0, gnt_log[g0 & 63], gnt_log[(g0 + 1) & 63],
                          gnt_log[(g0 + 2) & 63], gnt_log[(g0 + 3) & 63]}, 32'b0101);
    check_eq("rr_expq", exp_q.size(), 32'd0);

    // basic two-byte transfer on requester 0
    b_wren = c_wren; b_rxv0 = c_rxv0; b_done0 = c_done0; p0 = tx_ptr0;
    tx0_tbl[tx_ptr0 & 63] = 8'hA1; tx0_tbl[(tx_ptr0 + 1) & 63] = 8'h5C;
    rsp_tbl[rsp_ptr & 63] = 8'hF0; rsp_tbl[(rsp_ptr + 1) & 63] = 8'h0F;
    exp_q.push_back(8'hF0); exp_q.push_back(8'h0F);
    bus.len0_i = 4'd2; bus.req_i = 2'b01;
    for (n = 0; n < 50 && bus.ssn_o[0]; n++) @(negedge clk);
    for (n = 0; n < 50 && !bus.core_wren_o; n++) @(negedge clk);
    check_eq("b2_setup_cycles", n, 32'd4);
    wait_end(200, d, e);
    check_eq("b2_done", {28'h0, d, e}, 32'b0100);
    settle(2);
    check_eq("b2_ssn_after", {30'h0, bus.ssn_o}, 32'h3);
    check_eq("b2_gnt_after", {30'h0, bus.gnt_o}, 32'h0);
    check_eq("b2_wren_cnt", c_wren - b_wren, 32'd2);
    check_eq("b2_txrd_cnt", tx_ptr0 - p0, 32'd2);
    check_eq("b2_rxv_cnt", c_rxv0 - b_rxv0, 32'd2);
    check_eq("b2_done_cnt", c_done0 - b_done0, 32'd1);
    check_eq("b2_expq", exp_q.size(), 32'd0);

    // length 0 on requester 1 means 16 bytes at DIV1
    b_wren = c_wren; b_rxv1 = c_rxv1; b_done1 = c_done1; b_div = c_divbad;
    for (int k = 0; k < 16; k++) begin
      tx1_tbl[(tx_ptr1 + k) & 63] = 8'h40 + 8'(k);
      rsp_tbl[(rsp_ptr + k) & 63] = 8'hC0 + 8'(k);
      exp_q.push_back(8'hC0 + 8'(k));
    end
    bus.len1_i = 4'd0; bus.req_i = 2'b10;
    wait_end(600, d, e);
    check_eq("l16_done", {28'h0, d, e}, 32'b1000);
    settle(2);
    check_eq("l16_wren_cnt", c_wren - b_wren, 32'd16);
    check_eq("l16_rxv_cnt", c_rxv1 - b_rxv1, 32'd16);
    check_eq("l16_done_cnt", c_done1 - b_done1, 32'd1);
    check_eq("l16_div_bad", c_divbad - b_div, 32'd0);
    check_eq("l16_div_hold", {23'h0, bus.core_clk_div_o}, {23'h0, TB_DIV1});
    check_eq("l16_expq", exp_q.size(), 32'd0);

    // timeout: core never answers
    core_en = 1'b0;
    b_done0 = c_done0; b_err0 = c_err0;
    tx0_tbl[tx_ptr0 & 63] = 8'h77;
    bus.len0_i = 4'd1; bus.req_i = 2'b01;
    wait_wren(50);
    for (n = 0; n < 1100 && bus.err_o == 2'b00; n++) @(negedge clk);
    check_eq("tmo_latency", n, TMO);
    check_eq("tmo_err", {30'h0, bus.err_o}, 32'h1);
    check_eq("tmo_ssn", {30'h0, bus.ssn_o}, 32'h3);
    check_eq("tmo_gnt", {30'h0, bus.gnt_o}, 32'h0);
    bus.req_i = 2'b00;
    settle(3);
    check_eq("tmo_no_done", c_done0 - b_done0, 32'd0);
    check_eq("tmo_err_cnt", c_err0 - b_err0, 32'd1);
    core_en = 1'b1;

    // reset while waiting for a byte, then a clean transfer
    b_done0 = c_done0; b_done1 = c_done1; b_err0 = c_err0; b_err1 = c_err1; b_rxv1 = c_rxv1;
    tx1_tbl[tx_ptr1 & 63] = 8'h81; tx1_tbl[(tx_ptr1 + 1) & 63] = 8'h82;
    bus.len1_i = 4'd2; bus.req_i = 2'b10;
    for (n = 0; n < 50 && bus.state_o != 3'd3; n++) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("ra_ssn", {30'h0, bus.ssn_o}, 32'h3);
    check_eq("ra_gnt", {30'h0, bus.gnt_o}, 32'h0);
    check_eq("ra_pulses", {23'h0, bus.core_wren_o, bus.rx_valid_o, bus.done_o, bus.err_o}, 32'h0);
    check_eq("ra_div", {23'h0, bus.core_clk_div_o}, {23'h0, TB_DIV0});
    check_eq("ra_state", {29'h0, bus.state_o}, 32'h0);
    bus.req_i = 2'b00;
    settle(3);
    rst = 1'b0;
    settle(1);
    tx1_tbl[tx_ptr1 & 63] = 8'h83;
    rsp_tbl[rsp_ptr & 63] = 8'h5A;
    exp_q.push_back(8'h5A);
    bus.len1_i = 4'd1; bus.req_i = 2'b10;
    wait_end(200, d, e);
    check_eq("ra_done", {28'h0, d, e}, 32'b1000);
    settle(2);
    check_eq("ra_done_cnt", (c_done0 - b_done0) + (c_done1 - b_done1), 32'd1);
    check_eq("ra_err_cnt", (c_err0 - b_err0) + (c_err1 - b_err1), 32'd0);
    check_eq("ra_rxv_cnt", c_rxv1 - b_rxv1, 32'd1);
    check_eq("ra_expq", exp_q.size(), 32'd0);

    // spurious core_valid outside WAIT
    spur_mode = 1'b1;
    settle(4);
    b_wren = c_wren; b_rxv0 = c_rxv0; b_done0 = c_done0;
    tx0_tbl[tx_ptr0 & 63] = 8'h99;
    rsp_tbl[rsp_ptr & 63] = 8'h3C;
    exp_q.push_back(8'h3C);
    bus.len0_i = 4'd1; bus.req_i = 2'b01;
    wait_end(200, d, e);
    check_eq("sp_done", {28'h0, d, e}, 32'b0100);
    settle(4);
    spur_mode = 1'b0;
    check_eq("sp_wren_cnt", c_wren - b_wren, 32'd1);
    check_eq("sp_rxv_cnt", c_rxv0 - b_rxv0, 32'd1);
    check_eq("sp_done_cnt", c_done0 - b_done0, 32'd1);
    check_eq("sp_rxdata", {24'h0, bus.rx_data_o}, 32'h3C);
    check_eq("sp_expq", exp_q.size(), 32'd0);

    check_eq("invariants", c_viol, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
